// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered, handshaked ID-stage main-control decoder with M-extension issue hold.
// Optional build macro CTRL_PIPE_PERF_EN adds perf_issued/perf_stall/perf_illegal counters.

package ctrl_pipe_pkg;
  // Control bundle carried in the ID/EX register
  typedef struct packed {
    logic       br;
    logic       mem_read;
    logic       mem2reg;
    logic       mem_write;
    logic       regs_write;
    logic       br_addr_mode;
    logic [2:0] alu_op;
    logic [1:0] alu_src1;
    logic [1:0] alu_src2;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;
endpackage

module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        br,
  output logic        mem_read,
  output logic        mem2reg,
  output logic        mem_write,
  output logic        regs_write,
  output logic        br_addr_mode,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_src1,
  output logic [1:0]  alu_src2,
  output logic        muldiv,
  output logic        illegal
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_illegal
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_ALT = 2'b01;  // PC for src1, IMM for src2
  localparam logic [1:0] SRC_SPC = 2'b10;  // NULL for src1, PC_PLUS4 for src2

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d, dec_c;
  logic             accept_c;
  logic             unused_inst_bits;

  function automatic ctrl_t decode(input logic [31:0] i);
    ctrl_t d;
    d = '0;
    case (i[6:0])
      7'b0000011: begin  // LOAD
        d.mem_read = 1'b1; d.mem2reg = 1'b1; d.regs_write = 1'b1;
        d.alu_op = 3'b000; d.alu_src2 = SRC_ALT;
      end
      7'b0100011: begin  // STORE
        d.mem_write = 1'b1; d.alu_op = 3'b000; d.alu_src2 = SRC_ALT;
      end
      7'b1100011: begin d.br = 1'b1; d.alu_op = 3'b001; end
      7'b1100111: begin  // JALR
        d.br = 1'b1; d.br_addr_mode = 1'b1; d.regs_write = 1'b1;
        d.alu_op = 3'b100; d.alu_src1 = SRC_ALT; d.alu_src2 = SRC_SPC;
      end
      7'b1101111: begin  // JAL
        d.br = 1'b1; d.regs_write = 1'b1;
        d.alu_op = 3'b100; d.alu_src1 = SRC_ALT; d.alu_src2 = SRC_SPC;
      end
      7'b0110111: begin  // LUI
        d.regs_write = 1'b1; d.alu_op = 3'b000;
        d.alu_src1 = SRC_SPC; d.alu_src2 = SRC_ALT;
      end
      7'b0010111: begin  // AUIPC
        d.regs_write = 1'b1; d.alu_op = 3'b000;
        d.alu_src1 = SRC_ALT; d.alu_src2 = SRC_ALT;
      end
      7'b0110011: begin  // OP, including M-extension
        d.regs_write = 1'b1; d.alu_op = 3'b010;
        d.muldiv = (i[31:25] == 7'b0000001);
      end
      7'b0010011: begin d.regs_write = 1'b1; d.alu_op = 3'b011; d.alu_src2 = SRC_ALT; end
      7'b0111011: begin d.regs_write = 1'b1; d.alu_op = 3'b101; end
      default:    begin d.illegal = 1'b1; d.alu_op = 3'b111; end
    endcase
    return d;
  endfunction

  assign dec_c            = decode(inst);
  assign unused_inst_bits = ^inst[24:7];
  assign in_ready = rstn && (state_q == IDLE) && (!valid_q || out_ready) && !flush;
  assign accept_c = in_valid && in_ready;

  // Next-state: flush kills everything; IDLE accepts/drains; BUSY counts down the M-op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      state_d        = IDLE;
      cnt_d          = '0;
      valid_d        = 1'b0;
      ctrl_d.illegal = 1'b0;
      ctrl_d.muldiv  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_q && out_ready) valid_d = 1'b0;
          if (accept_c) begin
            ctrl_d = dec_c;
            if (dec_c.muldiv) begin
              state_d = BUSY;
              cnt_d   = CNT_LOAD;
              valid_d = 1'b0;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  // Event counters; free-running with wrap, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_issued  <= '0;
      perf_stall   <= '0;
      perf_illegal <= '0;
    end else begin
      if (valid_q && out_ready)                  perf_issued  <= perf_issued + 32'd1;
      if (in_valid && !in_ready)                 perf_stall   <= perf_stall + 32'd1;
      if (valid_q && out_ready && ctrl_q.illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

  assign out_valid    = valid_q;
  assign br           = ctrl_q.br;
  assign mem_read     = ctrl_q.mem_read;
  assign mem2reg      = ctrl_q.mem2reg;
  assign mem_write    = ctrl_q.mem_write;
  assign regs_write   = ctrl_q.regs_write;
  assign br_addr_mode = ctrl_q.br_addr_mode;
  assign alu_op       = ctrl_q.alu_op;
  assign alu_src1     = ctrl_q.alu_src1;
  assign alu_src2     = ctrl_q.alu_src2;
  assign muldiv       = ctrl_q.muldiv;
  assign illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized traffic
// against a cycle-deadline reference model.

module tb_ctrl_pipe;
  localparam int MC = 8;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_MUL  = 32'h02208033;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic clk = 1'b0;
  logic rstn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst;
  logic br, mem_read, mem2reg, mem_write, regs_write, br_addr_mode, muldiv, illegal;
  logic [2:0] alu_op;
  logic [1:0] alu_src1, alu_src2;
  logic [14:0] dut_vec;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_issued, perf_stall, perf_illegal;
`endif

  always #5 clk = ~clk;

  ctrl_pipe #(.MULDIV_CYCLES(MC), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .br(br),
    .mem_read(mem_read), .mem2reg(mem2reg), .mem_write(mem_write),
    .regs_write(regs_write), .br_addr_mode(br_addr_mode), .alu_op(alu_op),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .muldiv(muldiv), .illegal(illegal)
`ifdef CTRL_PIPE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_illegal(perf_illegal)
`endif
  );

  assign dut_vec = {br, mem_read, mem2reg, mem_write, regs_write, br_addr_mode,
                    alu_op, alu_src1, alu_src2, muldiv, illegal};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 0;

  // Reference model state: what is presented, and the cycle an M-op result appears
  bit          m_valid = 0;
  bit          m_busy  = 0;
  int          m_done  = 0;
  logic [14:0] m_b     = '0;
  logic [31:0] m_issued = 0, m_stall = 0, m_ill = 0;

  // Expected control vector from the opcode tables
  function automatic logic [14:0] ref_dec(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] aop;
    logic [1:0] s1, s2;
    op = i[6:0];
    if (!(op inside {7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h13, 7'h3B}))
      return {6'b0, 3'b111, 4'b0, 1'b0, 1'b1};
    if (op inside {7'h03, 7'h23, 7'h37, 7'h17}) aop = 3'd0;
    else if (op == 7'h63) aop = 3'd1;
    else if (op == 7'h33) aop = 3'd2;
    else if (op == 7'h13) aop = 3'd3;
    else if (op inside {7'h67, 7'h6F}) aop = 3'd4;
    else aop = 3'd5;
    s1 = (op inside {7'h6F, 7'h67, 7'h17}) ? 2'd1 : (op == 7'h37) ? 2'd2 : 2'd0;
    s2 = (op inside {7'h03, 7'h23, 7'h17, 7'h13, 7'h37}) ? 2'd1 :
         (op inside {7'h6F, 7'h67}) ? 2'd2 : 2'd0;
    return {logic'(op inside {7'h63, 7'h67, 7'h6F}), logic'(op == 7'h03), logic'(op == 7'h03),
            logic'(op == 7'h23), logic'(!(op inside {7'h23, 7'h63})), logic'(op == 7'h67),
            aop, s1, s2, logic'(op == 7'h33 && i[31:25] == 7'b0000001), 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, compare against model, advance model, return after posedge
  task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                      input logic fl, input logic ordy);
    bit rdy, hs;
    @(negedge clk);
    rstn = r; in_valid = iv; inst = ins; flush = fl; out_ready = ordy;
    #1;
    rdy = r && !fl && !m_busy && (!m_valid || ordy);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("bundle", 32'(dut_vec), 32'(m_b));
`ifdef CTRL_PIPE_PERF_EN
      chk("perf_issued", perf_issued, m_issued);
      chk("perf_stall", perf_stall, m_stall);
      chk("perf_illegal", perf_illegal, m_ill);
`endif
    end
    hs = m_valid && ordy;
    if (!r) begin
      m_valid = 0; m_busy = 0; m_issued = 0; m_stall = 0; m_ill = 0;
    end else begin
      if (hs) m_issued = m_issued + 1;
      if (iv && !rdy) m_stall = m_stall + 1;
      if (hs && m_b[0]) m_ill = m_ill + 1;
      if (fl) begin
        m_valid = 0; m_busy = 0;
      end else if (m_busy) begin
        if (cyc + 1 == m_done) begin m_busy = 0; m_valid = 1; end
      end else begin
        if (hs) m_valid = 0;
        if (iv && rdy) begin
          m_b = ref_dec(ins);
          if (m_b[1]) begin m_busy = 1; m_done = cyc + MC; m_valid = 0; end
          else m_valid = 1;
        end
      end
    end
    cyc++;
    started = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0] ops [10];
    ops = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h13, 7'h3B};
    w = $urandom;
    case ($urandom_range(0, 13))
      10, 11:  begin w[6:0] = 7'h33; w[31:25] = 7'b0000001; end
      12:      w[6:0] = 7'(($urandom_range(0, 127)));
      13:      begin w[6:0] = 7'h3B; w[31:25] = 7'b0000001; end
      default: w[6:0] = ops[$urandom_range(0, 9)];
    endcase
    return w;
  endfunction

  initial begin
    rstn = 0; in_valid = 0; inst = '0; flush = 0; out_ready = 0;

    // Reset held with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      step(0, 1, I_LW, 0, 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_controls", 32'(dut_vec), 0);
    end
    rstn = 1; in_valid = 0; #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // Single LW
    step(1, 1, I_LW, 0, 1);
    chk("lw_valid", 32'(out_valid), 1);
    chk("lw_mem", 32'({mem_read, mem2reg, regs_write}), 32'b111);
    chk("lw_alu_op", 32'(alu_op), 0);
    chk("lw_src2", 32'(alu_src2), 1);
    step(1, 0, 0, 0, 1);

    // MUL occupies the block for MC cycles
    step(1, 1, I_MUL, 0, 1);
    for (int i = 1; i < MC; i++) begin
      chk("mul_wait_valid", 32'(out_valid), 0);
      chk("mul_wait_ready", 32'(in_ready), 0);
      step(1, 0, 0, 0, 0);
    end
    chk("mul_valid", 32'(out_valid), 1);
    chk("mul_muldiv", 32'(muldiv), 1);
    chk("mul_alu_op", 32'(alu_op), 3'b010);
    step(1, 0, 0, 0, 1);

    // JAL under backpressure, then back-to-back ADDI
    step(1, 1, I_JAL, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("jal_hold", 32'({out_valid, br, alu_src1, alu_src2}), 32'b1_1_01_10);
      chk("jal_in_ready", 32'(in_ready), 0);
      step(1, 1, I_ADDI, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, I_ADDI, 0, 1);
      chk("addi_stream", 32'({out_valid, br, alu_op}), 32'b1_0_011);
    end
    step(1, 0, 0, 0, 1);

    // Flush during BUSY cycle 3 with a competing in_valid
    step(1, 1, I_MUL, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, I_ADDI, 1, 1);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_cleared", 32'({muldiv, illegal}), 0);
    flush = 0; in_valid = 0; out_ready = 1; #1;
    chk("flush_idle_ready", 32'(in_ready), 1);
    for (int i = 0; i < MC; i++) step(1, 0, 0, 0, 1);

    // Illegal opcode still issued
    step(1, 1, I_ILL, 0, 1);
    chk("ill_valid", 32'(out_valid), 1);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_alu_op", 32'(alu_op), 3'b111);
    chk("ill_regs_write", 32'(regs_write), 0);
    step(1, 0, 0, 0, 1);
`ifdef CTRL_PIPE_PERF_EN
    chk("perf_illegal_one", perf_illegal, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 9) < 7), rand_inst(),
           logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
